// File: rtl/reg_write_bank_pkg.sv
// Shared sizing constants for the general register file write bank.
package reg_write_bank_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned PC_IDX   = 15;

    localparam logic [DATA_W-1:0] RESET_VAL = '0;

endpackage

// File: rtl/reg_write_bank_if.sv
// Write ports, PC load path and register contents of the register write bank.
interface reg_write_bank_if
    import reg_write_bank_pkg::*;
();

    logic                 we_a;
    logic [ADDR_W-1:0]    waddr_a;
    logic [DATA_W-1:0]    wdata_a;
    logic                 we_b;
    logic [ADDR_W-1:0]    waddr_b;
    logic [DATA_W-1:0]    wdata_b;
    logic                 pc_ld;
    logic [DATA_W-1:0]    pc_in;
    // q[i] is register Ri; q[PC_IDX] is the program counter.
    logic [NUM_REGS-1:0][DATA_W-1:0] q;
    logic                 wr_conflict;

    modport master (
        output we_a, waddr_a, wdata_a,
        output we_b, waddr_b, wdata_b,
        output pc_ld, pc_in,
        input  q, wr_conflict
    );

    modport slave (
        input  we_a, waddr_a, wdata_a,
        input  we_b, waddr_b, wdata_b,
        input  pc_ld, pc_in,
        output q, wr_conflict
    );

endinterface

// File: rtl/reg_write_bank_binary_decoder.sv
// Binary-to-one-hot decoder with enable; output is all zeros when disabled.
module binary_decoder #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                 i_en,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [2**ADDR_W-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_bank.sv
// 16 x 32 register storage with two write ports and a PC load path into R15.
module reg_write_bank
    import reg_write_bank_pkg::*;
(
    input logic             clk,
    input logic             reset,
    reg_write_bank_if.slave bus
);

    logic [NUM_REGS-1:0]             w_sel_a;
    logic [NUM_REGS-1:0]             w_sel_b;
    logic [NUM_REGS-1:0]             w_sel_pc;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_q_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] r_q;
    logic                            w_conflict;
    logic                            r_wr_conflict;

    binary_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec_a (
        .i_en     (bus.we_a),
        .i_addr   (bus.waddr_a),
        .o_onehot (w_sel_a)
    );

    binary_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec_b (
        .i_en     (bus.we_b),
        .i_addr   (bus.waddr_b),
        .o_onehot (w_sel_b)
    );

    always_comb begin
        w_sel_pc         = '0;
        w_sel_pc[PC_IDX] = bus.pc_ld;
    end

    // Per-register priority: port A, then port B, then the PC path, else hold.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign w_q_d[i] = w_sel_a[i]  ? bus.wdata_a :
                          w_sel_b[i]  ? bus.wdata_b :
                          w_sel_pc[i] ? bus.pc_in   :
                                        r_q[i];
    end

    assign w_conflict = bus.we_a & bus.we_b & (bus.waddr_a == bus.waddr_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_q[i] <= RESET_VAL;
            end
            r_wr_conflict <= 1'b0;
        end else begin
            r_q           <= w_q_d;
            r_wr_conflict <= w_conflict;
        end
    end

    assign bus.q           = r_q;
    assign bus.wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_reg_write_bank.sv
// Scoreboard bench: directed vectors push expected state, a negedge monitor compares.
module tb_reg_write_bank;
    import reg_write_bank_pkg::*;

    typedef struct packed {
        logic [NUM_REGS-1:0][DATA_W-1:0] q;
        logic                            conf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_write_bank_if bus ();

    reg_write_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t                            exp_q[$];
    logic [NUM_REGS-1:0][DATA_W-1:0] m_regs;
    logic                            m_conf;
    int                              checks = 0;
    int                              errors = 0;

    task automatic idle_inputs();
        bus.we_a    = 1'b0;
        bus.waddr_a = '0;
        bus.wdata_a = '0;
        bus.we_b    = 1'b0;
        bus.waddr_b = '0;
        bus.wdata_b = '0;
        bus.pc_ld   = 1'b0;
        bus.pc_in   = '0;
    endtask

    // Sample edge, then queue the hand-computed state the DUT must show after it.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        e.q    = m_regs;
        e.conf = m_conf;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NUM_REGS; i++) begin
                checks++;
                if (bus.q[i] !== e.q[i]) begin
                    errors++;
                    $display("FAIL q%0d: got %h want %h", i, bus.q[i], e.q[i]);
                end
            end
            checks++;
            if (bus.wr_conflict !== e.conf) begin
                errors++;
                $display("FAIL wr_conflict: got %b want %b", bus.wr_conflict, e.conf);
            end
        end
    end

    initial begin
        idle_inputs();
        reset  = 1'b1;
        m_regs = '0;
        m_conf = 1'b0;
        tick();
        reset = 1'b0;

        // Preload R3 and R15 so the reset check below has something to clear.
        bus.we_a = 1'b1; bus.waddr_a = 4'd3; bus.wdata_a = 32'h0000_0033;
        bus.pc_ld = 1'b1; bus.pc_in = 32'h0000_0044;
        m_regs[3]  = 32'h0000_0033;
        m_regs[15] = 32'h0000_0044;
        tick();

        // Reset with writes pending: writes discarded, conflict suppressed.
        reset = 1'b1;
        bus.we_a = 1'b1; bus.waddr_a = 4'd3;  bus.wdata_a = 32'h0000_0055;
        bus.we_b = 1'b1; bus.waddr_b = 4'd3;  bus.wdata_b = 32'h0000_0077;
        bus.pc_ld = 1'b1; bus.pc_in = 32'h0000_0066;
        m_regs = '0;
        m_conf = 1'b0;
        tick();
        reset = 1'b0;
        idle_inputs();

        for (int i = 0; i < NUM_REGS; i++) begin
            bus.we_a    = 1'b1;
            bus.waddr_a = 4'(i);
            bus.wdata_a = 32'hA000_0000 + 32'(i);
            m_regs[i]   = 32'hA000_0000 + 32'(i);
            tick();
        end
        idle_inputs();

        bus.we_a = 1'b1; bus.waddr_a = 4'd2; bus.wdata_a = 32'h1111_1111;
        bus.we_b = 1'b1; bus.waddr_b = 4'd7; bus.wdata_b = 32'h2222_2222;
        m_regs[2] = 32'h1111_1111;
        m_regs[7] = 32'h2222_2222;
        tick();

        bus.we_a = 1'b1; bus.waddr_a = 4'd5; bus.wdata_a = 32'hDEAD_BEEF;
        bus.we_b = 1'b1; bus.waddr_b = 4'd5; bus.wdata_b = 32'hCAFE_F00D;
        m_regs[5] = 32'hDEAD_BEEF;
        m_conf    = 1'b1;
        tick();
        idle_inputs();
        m_conf = 1'b0;
        tick();

        bus.pc_ld = 1'b1; bus.pc_in = 32'h0000_0008;
        m_regs[15] = 32'h0000_0008;
        tick();
        bus.pc_in = 32'h0000_000C;
        bus.we_b = 1'b1; bus.waddr_b = 4'd15; bus.wdata_b = 32'h0000_0100;
        m_regs[15] = 32'h0000_0100;
        tick();

        // A and B both to R15 with pc_ld: A wins and flags a conflict.
        bus.we_a = 1'b1; bus.waddr_a = 4'd15; bus.wdata_a = 32'h0000_0ABC;
        bus.wdata_b = 32'h0000_0DEF;
        bus.pc_in = 32'h0000_0010;
        m_regs[15] = 32'h0000_0ABC;
        m_conf     = 1'b1;
        tick();

        bus.waddr_a = 4'd1; bus.wdata_a = 32'h0101_0101;
        bus.waddr_b = 4'd4; bus.wdata_b = 32'h0404_0404;
        bus.pc_in = 32'h0000_0020;
        m_regs[1]  = 32'h0101_0101;
        m_regs[4]  = 32'h0404_0404;
        m_regs[15] = 32'h0000_0020;
        m_conf     = 1'b0;
        tick();

        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            bus.waddr_a = 4'($urandom_range(0, 15));
            bus.wdata_a = $urandom;
            bus.waddr_b = 4'($urandom_range(0, 15));
            bus.wdata_b = $urandom;
            bus.pc_in   = $urandom;
            tick();
        end
        idle_inputs();

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_bank.md
Name: reg_write_bank

Overview:
- Write side of the 16 x 32-bit general register file. It holds the storage and drives the Q0..Q15 vectors that the 16:1 read multiplexers select from.
- Provides two synchronous write ports:
  - Port A: ALU/load result.
  - Port B: base-register writeback.
- Provides a dedicated program-counter path into R15.
- All updates are registered; the new values become visible on Q outputs one clock after the write is sampled.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width (16 registers)
- PC_IDX, 15, index of the register that also serves as program counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers on the clock edge where it is sampled high
- we_a  input  1  write enable, port A
- waddr_a  input  4  destination register, port A
- wdata_a  input  32  write data, port A
- we_b  input  1  write enable, port B
- waddr_b  input  4  destination register, port B
- wdata_b  input  32  write data, port B
- pc_ld  input  1  load R15 from pc_in
- pc_in  input  32  next program counter value
- Q0..Q15  output  32 each  current register contents (Q15 = PC), driven directly from storage flops
- wr_conflict  output  1  registered flag: the previous cycle had port A and port B writing the same address

Behaviour:
- Reset:
  - On a rising edge with reset=1, all Q0..Q15 = 32'h0000_0000 and wr_conflict=0.
  - Reset overrides every enable in the same cycle.
  - Reset asserted mid-sequence discards any write sampled on that edge.
- Per register i, at each rising edge with reset=0, the update follows this priority:
  1. Port A: we_a=1 and waddr_a==i -> Q_i <= wdata_a.
  2. Port B: else if we_b=1 and waddr_b==i -> Q_i <= wdata_b.
  3. PC load: else if i==PC_IDX and pc_ld=1 -> Q_i <= pc_in.
  4. Otherwise: Q_i holds.
- Same-address writes: port A wins. wr_conflict <= (we_a & we_b & (waddr_a==waddr_b)) on the same edge.
- R15 handling:
  - A port A or port B write to R15 overrides pc_ld in that cycle (branch/load-to-PC takes precedence over sequential fetch).
  - Simultaneous port A to R15 and port B to R15 -> port A value, wr_conflict=1.
- Writes to different addresses on A, B and the PC path in one cycle all take effect on the same edge.
- Latency:
  - A write sampled at edge N is visible on Q at edge N (registered output), i.e. readable by the mux in cycle N+1.
  - There is no internal bypass; forwarding is the pipeline's responsibility.
- Each decoded enable is a one-hot 16-bit vector, all zeros when the port enable is low.
- All 16 registers are writable, including R0; there is no hardwired-zero register.
- wr_conflict is purely diagnostic. It is asserted for exactly one cycle per conflicting edge and cleared by reset.

Decomposition:
- Shared package: DATA_W, ADDR_W, NUM_REGS=16, PC_IDX=15, RESET_VAL=32'h0.
- Sub-module binary_decoder: 4-to-16 one-hot decoder with enable input. It is instantiated twice, once for port A and once for port B.
- The top level holds the 16 register flops and the per-register priority logic.
- The generate loop over i covers the register bodies; R15 gets the extra pc_ld term.

Test Plan:
- Reset check: drive writes to R3 and R15, then assert reset for one edge -> all Q=0 and wr_conflict=0 on that edge; the write data is not stored.
- Port A, all registers: we_a=1, waddr_a=i, wdata_a=32'hA000_0000+i, for i=0..15 -> each Q_i updates on its edge and all other Q hold.
- Dual port, different addresses: A writes R2=32'h1111_1111 and B writes R7=32'h2222_2222 in one cycle -> both update on the same edge; wr_conflict=0.
- Collision: A and B both write R5 (A=32'hDEAD_BEEF, B=32'hCAFE_F00D) -> Q5=32'hDEAD_BEEF and wr_conflict=1 for one cycle only.
- PC path: pc_ld=1 with pc_in=32'h0000_0008 -> Q15=8. The next cycle has pc_ld=1, pc_in=12, and port B writes R15=32'h0000_0100 -> Q15=32'h100.
- Idle hold: all enables low for 10 cycles with random data, waddr and pc_in -> no Q changes.
